beat_sequencer: RTL and testbench
=================================

Name: beat_sequencer

Overview:
- Run/halt/single-step controller for the CPU's one-hot beat timing.
- Produces the beat vector t (t0..t5) consumed by the control-signal decoder.
- Supports variable-length instructions (early return to t0), memory wait stalls, halt at an instruction boundary, and an instruction counter.
- Sits between the front-panel/debug controls and the instruction decoder.

Parameters:
- NBEATS, 6: number of beats per maximum-length instruction cycle (t0..t(NBEATS-1)).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  level; start continuous execution from IDLE.
- step  in  1  level; execute exactly one instruction from IDLE.
- halt_req  in  1  stop request from the decoder (HLT) or the debug panel.
- mem_wait  in  1  memory not ready; freeze the current beat.
- last_beat  in  1  decoder flags the current beat as the final beat of this instruction.
- t  out  NBEATS  one-hot beat vector, bit 0 = t0; all-zero when idle.
- cycle_start  out  1  1-cycle pulse on the first clock of each t0.
- running  out  1  high in RUN or STEP state.
- instr_cnt  out  CNT_W  count of completed instructions.

Behaviour:
- Reset, asynchronous and immediate, including mid-instruction:
  - state = IDLE, t = 0, cycle_start = 0, running = 0, instr_cnt = 0, halt_pend = 0.
- States:
  - IDLE: t = 0.
  - RUN: continuous execution.
  - STEP: one instruction, then IDLE.
- IDLE transitions:
  - run = 1 -> RUN.
  - else step = 1 -> STEP.
  - run has priority over step.
  - Next cycle: t = 1 (t0), cycle_start = 1, running = 1.
  - The registered transition gives one cycle of latency from the sampled request to t0.
- RUN/STEP, each clock, in priority order:
  - mem_wait = 1: t holds, cycle_start = 0, no counter change. Outranks last_beat and halt.
  - Boundary = last_beat = 1, or t[NBEATS-1] = 1:
    - instr_cnt += 1, wrapping from 2^CNT_W-1 to 0.
    - Then, if STEP, halt_pend, or halt_req this cycle: go to IDLE, t = 0, running = 0, halt_pend cleared.
    - Else: t = t0, cycle_start = 1.
  - Otherwise: t rotates left by one (t_k -> t_k+1), cycle_start = 0.
- halt_req outside a boundary:
  - In RUN/STEP it sets sticky halt_pend.
  - The halt takes effect at the next boundary only. An instruction is never cut mid-beat.
- run or step asserted while in RUN/STEP: ignored.
- halt_req in IDLE: ignored, and does not set halt_pend.
- run held high: after a halt completes, returns to RUN the next cycle. A re-start requires the halt condition to have been taken, so the decoder deasserts halt_req.
- last_beat on t0: a legal 1-beat instruction, counted.
- Invariant: t is one-hot or all-zero at every clock edge.

Decomposition:
- Shared package cpu_timing_pkg:
  - state enum (IDLE, RUN, STEP).
  - NBEATS default constant.
  - Beat index constants T0..T5 for decoder use.
- Optional sub-module beat_ring: an NBEATS one-hot rotator with hold, load-t0, and clear inputs. The controller FSM and counter stay in beat_sequencer.

Test Plan:
- Reset then run pulse with NBEATS = 6, no waits:
  - t sequence 000001, 000010, ..., 100000, 000001.
  - cycle_start high every 6th cycle.
  - instr_cnt = 3 after 18 beat cycles.
- step pulse from IDLE:
  - Exactly six beats t0..t5, then t = 0, running = 0, instr_cnt = 1.
  - A second step gives instr_cnt = 2.
- last_beat asserted on t2 each instruction:
  - Period becomes 3 cycles (t0, t1, t2, t0).
  - instr_cnt increments every 3 cycles.
- mem_wait high for 4 cycles during t3:
  - t stays 001000 for 5 cycles total.
  - No cycle_start, no count, then continues to t4.
- halt_req pulsed for 1 cycle on t1:
  - Execution continues through t5, instr_cnt increments once, then IDLE with t = 0.
  - run and step both high in IDLE: enters RUN, not STEP.
- rst asserted asynchronously during t4:
  - t = 0, instr_cnt = 0, running = 0 before the next clk edge.
- Counter wrap with CNT_W = 4:
  - instr_cnt 15 -> 0.

Source files
------------

// File: rtl/cpu_timing_pkg.sv
// rtl/cpu_timing_pkg.sv - shared beat-timing types and constants for the sequencer and decoder
package cpu_timing_pkg;

    localparam int NBEATS_DEFAULT = 6;

    // Beat indices into the t vector, for the control-signal decoder.
    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/beat_ring.sv
// rtl/beat_ring.sv - one-hot beat rotator with clear, load-t0 and hold
module beat_ring #(
    parameter int NBEATS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              load_i,
    input  logic              clear_i,
    output logic [NBEATS-1:0] t_o
);

    logic [NBEATS-1:0] t_q;
    logic [NBEATS-1:0] t_d;

    // clear beats load, load beats hold; otherwise advance one beat
    always_comb begin
        t_d = t_q;
        if (clear_i) begin
            t_d = '0;
        end else if (load_i) begin
            t_d = {{(NBEATS-1){1'b0}}, 1'b1};
        end else if (!hold_i) begin
            t_d = {t_q[NBEATS-2:0], t_q[NBEATS-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_q <= '0;
        end else begin
            t_q <= t_d;
        end
    end

    assign t_o = t_q;

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - run/halt/single-step controller producing the one-hot beat vector
module beat_sequencer #(
    parameter int NBEATS = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              halt_req,
    input  logic              mem_wait,
    input  logic              last_beat,
    output logic [NBEATS-1:0] t,
    output logic              cycle_start,
    output logic              running,
    output logic [CNT_W-1:0]  instr_cnt
);

    import cpu_timing_pkg::*;

    seq_state_e       state_q, state_d;
    logic             cs_q, cs_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ring_hold;
    logic ring_load;
    logic ring_clear;
    logic boundary;

    beat_ring #(
        .NBEATS (NBEATS)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .hold_i  (ring_hold),
        .load_i  (ring_load),
        .clear_i (ring_clear),
        .t_o     (t)
    );

    assign boundary = last_beat | t[NBEATS-1];

    always_comb begin
        state_d    = state_q;
        cs_d       = 1'b0;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        ring_hold  = 1'b1;
        ring_load  = 1'b0;
        ring_clear = 1'b0;
        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (run) begin
                    state_d   = RUN;
                    ring_load = 1'b1;
                    cs_d      = 1'b1;
                end else if (step) begin
                    state_d   = STEP;
                    ring_load = 1'b1;
                    cs_d      = 1'b1;
                end
            end
            RUN, STEP: begin
                // A stall freezes the beat but still remembers a halt request.
                if (mem_wait) begin
                    if (halt_req) begin
                        pend_d = 1'b1;
                    end
                end else if (boundary) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (state_q == STEP || pend_q || halt_req) begin
                        state_d    = IDLE;
                        ring_clear = 1'b1;
                        pend_d     = 1'b0;
                    end else begin
                        ring_load = 1'b1;
                        cs_d      = 1'b1;
                    end
                end else begin
                    ring_hold = 1'b0;
                    if (halt_req) begin
                        pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                ring_clear = 1'b1;
                pend_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cs_q    <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cycle_start = cs_q;
    assign running     = (state_q != IDLE);
    assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// tb/tb_beat_sequencer.sv - randomized and directed self-checking bench for beat_sequencer
module tb_beat_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step;
    logic        halt_req;
    logic        mem_wait;
    logic        last_beat;
    logic [5:0]  t;
    logic        cycle_start;
    logic        running;
    logic [15:0] instr_cnt;
    logic [5:0]  t4;
    logic        cs4;
    logic        run4;
    logic [3:0]  cnt4;

    int vectors;
    int miscompares;

    // Reference model: beat index (-1 when idle), mode 0=idle 1=run 2=step.
    int          m_mode;
    int          m_beat;
    logic        m_cs;
    logic        m_pend;
    logic [15:0] m_cnt;

    beat_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .mem_wait    (mem_wait),
        .last_beat   (last_beat),
        .t           (t),
        .cycle_start (cycle_start),
        .running     (running),
        .instr_cnt   (instr_cnt)
    );

    beat_sequencer #(.NBEATS(6), .CNT_W(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .halt_req    (halt_req),
        .mem_wait    (mem_wait),
        .last_beat   (last_beat),
        .t           (t4),
        .cycle_start (cs4),
        .running     (run4),
        .instr_cnt   (cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] exp_t();
        logic [5:0] one;
        one = 6'b000001;
        if (m_beat < 0) return 6'b000000;
        return one << m_beat;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_beat = -1;
        m_cs   = 1'b0;
        m_pend = 1'b0;
        m_cnt  = '0;
    endtask

    // Advance one clock: update the model from the sampled inputs, then settle.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (m_mode == 0) begin
            m_cs = 1'b0;
            if (run) begin
                m_mode = 1; m_beat = 0; m_cs = 1'b1;
            end else if (step) begin
                m_mode = 2; m_beat = 0; m_cs = 1'b1;
            end
        end else if (mem_wait) begin
            m_cs = 1'b0;
            if (halt_req) m_pend = 1'b1;
        end else if (last_beat || m_beat == 5) begin
            m_cnt = m_cnt + 16'd1;
            if (m_mode == 2 || m_pend || halt_req) begin
                m_mode = 0; m_beat = -1; m_pend = 1'b0; m_cs = 1'b0;
            end else begin
                m_beat = 0; m_cs = 1'b1;
            end
        end else begin
            m_beat = m_beat + 1;
            m_cs   = 1'b0;
            if (halt_req) m_pend = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        run = 0; step = 0; halt_req = 0; mem_wait = 0; last_beat = 0;
    endtask

    task automatic stop_run(input string name);
        halt_req = 1'b1;
        for (int i = 0; i < 10 && m_mode != 0; i++) begin
            cyc();
            vectors++;
            if (t !== exp_t() || running !== (m_mode != 0) || instr_cnt !== m_cnt) begin
                miscompares++;
                $display("FAIL %s_stop: t=%b run=%b cnt=%0d expected t=%b run=%0d cnt=%0d",
                         name, t, running, instr_cnt, exp_t(), m_mode != 0, m_cnt);
            end
        end
        halt_req = 1'b0;
        vectors++;
        if (running !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_stop_timeout: running=%b expected 0", name, running);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        cyc();
        cyc();
        vectors++;
        if (t !== 6'b0 || cycle_start !== 1'b0 || running !== 1'b0 || instr_cnt !== 16'd0 || cnt4 !== 4'd0) begin
            miscompares++;
            $display("FAIL reset: t=%b cs=%b run=%b cnt=%0d expected all zero", t, cycle_start, running, instr_cnt);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_run_sequence();
        logic [5:0] one;
        one = 6'b000001;
        run = 1'b1;
        cyc();
        run = 1'b0;
        for (int i = 0; i < 19; i++) begin
            vectors++;
            if (t !== (one << (i % 6)) || cycle_start !== (i % 6 == 0) || running !== 1'b1 ||
                instr_cnt !== m_cnt || t !== exp_t()) begin
                miscompares++;
                $display("FAIL run_seq[%0d]: t=%b cs=%b cnt=%0d expected t=%b cs=%0d cnt=%0d",
                         i, t, cycle_start, instr_cnt, one << (i % 6), i % 6 == 0, m_cnt);
            end
            if (i < 18) cyc();
        end
        vectors++;
        if (instr_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL run_count: instr_cnt=%0d expected 3", instr_cnt);
        end
        stop_run("run_seq");
    endtask

    task automatic test_step();
        logic [15:0] base;
        base = m_cnt;
        for (int n = 1; n <= 2; n++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (t !== exp_t() || cycle_start !== m_cs || running !== 1'b1) begin
                    miscompares++;
                    $display("FAIL step_beat[%0d]: t=%b cs=%b run=%b expected t=%b cs=%b run=1",
                             i, t, cycle_start, running, exp_t(), m_cs);
                end
                cyc();
            end
            vectors++;
            if (t !== 6'b0 || running !== 1'b0 || instr_cnt !== base + 16'(n)) begin
                miscompares++;
                $display("FAIL step_end%0d: t=%b run=%b cnt=%0d expected t=0 run=0 cnt=%0d",
                         n, t, running, instr_cnt, base + 16'(n));
            end
        end
    endtask

    task automatic test_last_beat();
        logic [5:0] one;
        one = 6'b000001;
        run = 1'b1;
        cyc();
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (t !== (one << (i % 3)) || cycle_start !== (i % 3 == 0) || instr_cnt !== m_cnt) begin
                miscompares++;
                $display("FAIL last_beat[%0d]: t=%b cs=%b cnt=%0d expected t=%b cs=%0d cnt=%0d",
                         i, t, cycle_start, instr_cnt, one << (i % 3), i % 3 == 0, m_cnt);
            end
            last_beat = (m_beat == 2);
            cyc();
        end
        last_beat = 1'b0;
        stop_run("last_beat");
    endtask

    task automatic test_mem_wait();
        logic [15:0] base;
        run = 1'b1;
        cyc();
        run = 1'b0;
        cyc(); cyc(); cyc();
        base = instr_cnt;
        mem_wait = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) mem_wait = 1'b0;
            vectors++;
            if (t !== 6'b001000 || cycle_start !== 1'b0 || instr_cnt !== base) begin
                miscompares++;
                $display("FAIL mem_wait[%0d]: t=%b cs=%b cnt=%0d expected t=001000 cs=0 cnt=%0d",
                         i, t, cycle_start, instr_cnt, base);
            end
            if (i < 4) cyc();
        end
        cyc();
        vectors++;
        if (t !== 6'b010000 || t !== exp_t()) begin
            miscompares++;
            $display("FAIL mem_wait_resume: t=%b expected 010000", t);
        end
        stop_run("mem_wait");
    endtask

    task automatic test_halt();
        logic [15:0] base;
        base = m_cnt;
        run = 1'b1;
        cyc();
        run = 1'b0;
        cyc();
        halt_req = 1'b1;
        cyc();
        halt_req = 1'b0;
        for (int i = 2; i < 6; i++) begin
            vectors++;
            if (t !== exp_t() || running !== 1'b1) begin
                miscompares++;
                $display("FAIL halt_continue[%0d]: t=%b run=%b expected t=%b run=1", i, t, running, exp_t());
            end
            cyc();
        end
        vectors++;
        if (t !== 6'b0 || running !== 1'b0 || instr_cnt !== base + 16'd1) begin
            miscompares++;
            $display("FAIL halt_idle: t=%b run=%b cnt=%0d expected t=0 run=0 cnt=%0d",
                     t, running, instr_cnt, base + 16'd1);
        end
    endtask

    task automatic test_run_priority();
        run = 1'b1;
        step = 1'b1;
        cyc();
        run = 1'b0;
        step = 1'b0;
        for (int i = 0; i < 7; i++) cyc();
        vectors++;
        if (running !== 1'b1 || t !== 6'b000010 || t !== exp_t()) begin
            miscompares++;
            $display("FAIL run_priority: run=%b t=%b expected run=1 t=000010", running, t);
        end
        stop_run("priority");
    endtask

    task automatic test_wrap();
        logic       wrapped;
        logic [3:0] prev;
        wrapped = 1'b0;
        run = 1'b1;
        last_beat = 1'b1;
        cyc();
        run = 1'b0;
        prev = cnt4;
        for (int i = 0; i < 20; i++) begin
            cyc();
            vectors++;
            if (cnt4 !== m_cnt[3:0] || instr_cnt !== m_cnt || t4 !== exp_t()) begin
                miscompares++;
                $display("FAIL wrap[%0d]: cnt4=%0d cnt=%0d expected cnt4=%0d cnt=%0d",
                         i, cnt4, instr_cnt, m_cnt[3:0], m_cnt);
            end
            if (prev == 4'd15 && cnt4 == 4'd0) wrapped = 1'b1;
            prev = cnt4;
        end
        last_beat = 1'b0;
        vectors++;
        if (wrapped !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_seen: wrapped=%b expected 1", wrapped);
        end
        stop_run("wrap");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            run       = ($urandom % 20) == 0;
            step      = ($urandom % 15) == 0;
            mem_wait  = ($urandom % 4) == 0;
            halt_req  = !mem_wait && (($urandom % 10) == 0);
            last_beat = ($urandom % 5) == 0;
            cyc();
            vectors++;
            if (t !== exp_t() || cycle_start !== m_cs || running !== (m_mode != 0) ||
                instr_cnt !== m_cnt || cnt4 !== m_cnt[3:0] || !$onehot0(t)) begin
                miscompares++;
                $display("FAIL random[%0d]: t=%b cs=%b run=%b cnt=%0d expected t=%b cs=%b run=%0d cnt=%0d",
                         i, t, cycle_start, running, instr_cnt, exp_t(), m_cs, m_mode != 0, m_cnt);
            end
        end
        idle_inputs();
        if (m_mode != 0) stop_run("random");
    endtask

    task automatic test_async_reset();
        run = 1'b1;
        cyc();
        run = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        vectors++;
        if (t !== 6'b010000) begin
            miscompares++;
            $display("FAIL async_pre: t=%b expected 010000", t);
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (t !== 6'b0 || running !== 1'b0 || instr_cnt !== 16'd0 || cycle_start !== 1'b0 || cnt4 !== 4'd0) begin
            miscompares++;
            $display("FAIL async_reset: t=%b run=%b cnt=%0d cs=%b expected all zero",
                     t, running, instr_cnt, cycle_start);
        end
        cyc();
        rst = 1'b0;
        cyc();
        vectors++;
        if (running !== 1'b0 || t !== 6'b0) begin
            miscompares++;
            $display("FAIL async_after: run=%b t=%b expected idle", running, t);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_run_sequence();
        test_step();
        test_last_beat();
        test_mem_wait();
        test_halt();
        test_run_priority();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
